// File: rtl/sound_cue_player_if.sv
// Codec-side sample handshake: one-cycle request, answered next cycle with a valid pulse.
interface sound_cue_player_if;
    logic               sample_req;
    logic signed [15:0] sample_out;
    logic               sample_valid;

    modport master (output sample_req, input  sample_out, input  sample_valid);
    modport slave  (input  sample_req, output sample_out, output sample_valid);
endinterface

// File: rtl/sound_cue_player.sv
// Cue-driven square-wave jingle player: synchronises the cue bus, sequences note/gap
// timing and serves the current square-wave level on the codec sample handshake.
module sound_cue_player #(
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter logic [15:0] AMPLITUDE   = 16'd8192,
    parameter int unsigned TONE_SHIFT  = 0
) (
    input  logic              CLOCK_50,
    input  logic              Clr,
    input  logic [3:0]        SOUND_SELECT,
    sound_cue_player_if.slave bus,
    output logic              playing,
    output logic              cue_done
);
    localparam int DUR_W = $clog2(NOTE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [3:0] CUE_START = 4'b1010;
    localparam logic [3:0] CUE_GOAL  = 4'b1111;
    localparam logic [3:0] CUE_OFF_A = 4'b0000;
    localparam logic [3:0] CUE_OFF_B = 4'b1000;

    localparam logic [15:0] HP_C5 = 16'(47801 >> TONE_SHIFT);
    localparam logic [15:0] HP_E5 = 16'(37936 >> TONE_SHIFT);
    localparam logic [15:0] HP_G5 = 16'(31888 >> TONE_SHIFT);
    localparam logic [15:0] HP_C6 = 16'(23878 >> TONE_SHIFT);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_sync1, r_sync2, r_last;
    logic               r_goal, w_goal_nxt;
    logic [1:0]         r_note_idx, w_idx_nxt;
    logic [DUR_W-1:0]   r_dur, w_dur_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [15:0]        r_half, w_half_nxt;
    logic               r_phase, w_phase_nxt;
    logic               r_done, w_done_nxt;
    logic signed [15:0] r_sample_out;
    logic               r_sample_valid;

    logic               w_cue_chg, w_load_start, w_load_goal, w_abort;
    logic [15:0]        w_hp;
    logic signed [15:0] w_level;

    function automatic logic [15:0] half_period(input logic goal, input logic [1:0] idx);
        if (goal) return (idx == 2'd0) ? HP_G5 : HP_C6;
        case (idx)
            2'd0:    return HP_C5;
            2'd1:    return HP_E5;
            default: return HP_G5;
        endcase
    endfunction

    function automatic logic is_last_note(input logic goal, input logic [1:0] idx);
        return goal ? (idx == 2'd1) : (idx == 2'd2);
    endfunction

    function automatic logic signed [15:0] square_level(input state_t st, input logic ph);
        if (st != S_NOTE) return 16'sd0;
        return ph ? $signed(AMPLITUDE) : -$signed(AMPLITUDE);
    endfunction

    assign w_cue_chg    = (r_sync2 != r_last);
    assign w_load_start = w_cue_chg && (r_sync2 == CUE_START);
    assign w_load_goal  = w_cue_chg && (r_sync2 == CUE_GOAL);
    assign w_abort      = w_cue_chg && ((r_sync2 == CUE_OFF_A) || (r_sync2 == CUE_OFF_B));
    assign w_hp         = half_period(r_goal, r_note_idx);
    assign w_level      = square_level(r_state, r_phase);

    // Cue decode has priority over natural sequencing, which also suppresses cue_done.
    always_comb begin
        w_state_nxt = r_state;
        w_goal_nxt  = r_goal;
        w_idx_nxt   = r_note_idx;
        w_dur_nxt   = r_dur;
        w_gap_nxt   = r_gap;
        w_half_nxt  = r_half;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        if (w_load_start || w_load_goal) begin
            w_state_nxt = S_NOTE;
            w_goal_nxt  = w_load_goal;
            w_idx_nxt   = 2'd0;
            w_dur_nxt   = '0;
            w_gap_nxt   = '0;
            w_half_nxt  = '0;
            w_phase_nxt = 1'b1;
        end else if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            w_dur_nxt   = '0;
            w_gap_nxt   = '0;
            w_half_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else begin
            case (r_state)
                S_NOTE: begin
                    if (r_half == w_hp - 16'd1) begin
                        w_half_nxt  = '0;
                        w_phase_nxt = ~r_phase;
                    end else begin
                        w_half_nxt  = r_half + 16'd1;
                    end
                    if (r_dur == DUR_W'(NOTE_CYCLES - 1)) begin
                        w_state_nxt = S_GAP;
                        w_dur_nxt   = '0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_dur_nxt   = r_dur + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                        w_gap_nxt = '0;
                        if (is_last_note(r_goal, r_note_idx)) begin
                            w_state_nxt = S_IDLE;
                            w_idx_nxt   = 2'd0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_NOTE;
                            w_idx_nxt   = r_note_idx + 2'd1;
                            w_half_nxt  = '0;
                            w_phase_nxt = 1'b1;
                        end
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Clr) begin
        if (!Clr) begin
            r_state        <= S_IDLE;
            r_sync1        <= 4'b0000;
            r_sync2        <= 4'b0000;
            r_last         <= 4'b0000;
            r_goal         <= 1'b0;
            r_note_idx     <= 2'd0;
            r_dur          <= '0;
            r_gap          <= '0;
            r_half         <= '0;
            r_phase        <= 1'b0;
            r_done         <= 1'b0;
            r_sample_out   <= 16'sd0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sync1        <= SOUND_SELECT;
            r_sync2        <= r_sync1;
            r_last         <= r_sync2;
            r_state        <= w_state_nxt;
            r_goal         <= w_goal_nxt;
            r_note_idx     <= w_idx_nxt;
            r_dur          <= w_dur_nxt;
            r_gap          <= w_gap_nxt;
            r_half         <= w_half_nxt;
            r_phase        <= w_phase_nxt;
            r_done         <= w_done_nxt;
            r_sample_valid <= bus.sample_req;
            if (bus.sample_req) r_sample_out <= w_level;
        end
    end

    assign playing          = (r_state == S_NOTE) || (r_state == S_GAP);
    assign cue_done         = r_done;
    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;
endmodule

// File: tb/tb_sound_cue_player.sv
// Bench for sound_cue_player: directed cue scenarios plus randomized cue/request traffic,
// checked every cycle against a timeline model of the jingle.
module tb_sound_cue_player;
    localparam int NOTE_C = 100;
    localparam int GAP_C  = 20;
    localparam int TS     = 10;
    localparam int AMP    = 8192;
    localparam int SLOT   = NOTE_C + GAP_C;

    logic       CLOCK_50 = 1'b0;
    logic       Clr = 1'b0;
    logic [3:0] SOUND_SELECT = 4'b0000;
    logic       playing, cue_done;

    sound_cue_player_if bus();

    sound_cue_player #(
        .NOTE_CYCLES(NOTE_C), .GAP_CYCLES(GAP_C), .AMPLITUDE(16'd8192), .TONE_SHIFT(TS)
    ) dut (
        .CLOCK_50(CLOCK_50), .Clr(Clr), .SOUND_SELECT(SOUND_SELECT),
        .bus(bus), .playing(playing), .cue_done(cue_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_err = 0;

    // Reference: codes seen at the last three edges, and the start edge of the current jingle.
    logic [3:0] h [3];
    int  e = 0;
    int  t0 = 0;
    bit  active = 0;
    bit  goal = 0;
    int  m_out = 0;
    bit  m_valid = 0;
    bit  m_done = 0;
    int  req_mode = 0;
    int  start_hp [3] = '{47801, 37936, 31888};
    int  goal_hp  [2] = '{31888, 23878};

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int total_len();
        return goal ? 2 * SLOT : 3 * SLOT;
    endfunction

    function automatic int model_level();
        int el, w, hp;
        if (!active) return 0;
        el = e - t0;
        w  = el % SLOT;
        if (w >= NOTE_C) return 0;
        hp = goal ? (goal_hp[el / SLOT] >> TS) : (start_hp[el / SLOT] >> TS);
        return (((w / hp) % 2) == 0) ? AMP : -AMP;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) h[i] = 4'b0000;
        active = 0; m_out = 0; m_valid = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic [3:0] ss, input logic req);
        logic [3:0] code;
        int lvl;
        lvl = model_level();
        m_valid = req;
        if (req) m_out = lvl;
        m_done = 0;
        e++;
        code = h[1];
        if (h[1] != h[2] && (code == 4'b1010 || code == 4'b1111)) begin
            active = 1; goal = (code == 4'b1111); t0 = e;
        end else if (h[1] != h[2] && (code == 4'b0000 || code == 4'b1000)) begin
            active = 0;
        end else if (active && (e - t0) == total_len()) begin
            active = 0; m_done = 1;
        end
        h[2] = h[1]; h[1] = h[0]; h[0] = ss;
    endtask

    task automatic compare_all(input string where);
        check({where, ".valid"},   int'(bus.sample_valid), int'(m_valid));
        check({where, ".sample"},  int'($signed(bus.sample_out)), m_out);
        check({where, ".playing"}, int'(playing), int'(active));
        check({where, ".done"},    int'(cue_done), int'(m_done));
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (Clr) model_edge(SOUND_SELECT, bus.sample_req);
        #1;
        compare_all("cyc");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_req = (req_mode == 0) ? (i % 5 == 0) : ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.sample_req = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        Clr = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        for (int i = 0; i < hold; i++) tick();
        Clr = 1'b1;
    endtask

    initial begin
        logic [3:0] pick;
        bus.sample_req = 1'b0;
        // Power-up with the start cue already present
        SOUND_SELECT = 4'b1010;
        do_reset(3);
        run(400);
        // Goal jingle from idle
        SOUND_SELECT = 4'b0000; run(10);
        SOUND_SELECT = 4'b1111; run(260);
        // Preempt start by goal, then abort goal with silence
        SOUND_SELECT = 4'b1010; run(150);
        SOUND_SELECT = 4'b1111; run(60);
        SOUND_SELECT = 4'b1000; run(20);
        // Goal held across what would be two jingles
        SOUND_SELECT = 4'b1111; run(600);
        // Reset in the middle of a note, release with start held
        SOUND_SELECT = 4'b1010; run(50);
        do_reset(4);
        run(400);
        // Randomized cue traffic and request timing
        req_mode = 1;
        for (int s = 0; s < 30; s++) begin
            case ($urandom_range(0, 4))
                0: pick = 4'b1010;
                1: pick = 4'b1111;
                2: pick = 4'b0000;
                3: pick = 4'b1000;
                default: pick = 4'($urandom_range(0, 15));
            endcase
            SOUND_SELECT = pick;
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
            run($urandom_range(3, 300));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
